// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned DefStkHeight = 8;
  localparam int unsigned DefPtrWidth  = 3;
  // Occupancy needs one extra bit so that "full" (== height) is representable.
  localparam int unsigned DefCntWidth  = DefPtrWidth + 1;

  // Next pointer value: advance by one, returning to 0 after height-1.
  // Using >= keeps an out-of-range pointer from walking off into unused codes.
  function automatic int unsigned ptr_wrap_next(input int unsigned ptr,
                                                input int unsigned height);
    return (ptr >= height - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered pointer with enable, wrapping at stk_height-1 (height need not be a power of two).
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned stk_height    = DefStkHeight,
  parameter int unsigned stk_ptr_width = DefPtrWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  output logic [stk_ptr_width-1:0] ptr_o
);

  logic [stk_ptr_width-1:0] ptr_q, ptr_d;

  // Next pointer: hold, or advance with wrap when enabled.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = stk_ptr_width'(ptr_wrap_next(32'(ptr_q), stk_height));
    end
  end

  // Pointer register, async clear to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO sequencing controller: pointers, occupancy, status flags and
// qualified write/read strobes for the stack-style datapath.
// Optional sticky overflow/underflow reporting is enabled with `define FIFO_CTRL_ERR_EN.
module fifo_sync_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned stk_height    = DefStkHeight,
  parameter int unsigned stk_ptr_width = DefPtrWidth,
  parameter int unsigned af_thresh     = 6,
  parameter int unsigned ae_thresh     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic                     read,
`ifdef FIFO_CTRL_ERR_EN
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic                     write_to_stk,
  output logic                     read_fr_stk,
  output logic [stk_ptr_width-1:0] write_ptr,
  output logic [stk_ptr_width-1:0] read_ptr,
  output logic                     stk_full,
  output logic                     stk_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [stk_ptr_width:0]   count
);

  localparam int unsigned CntW = stk_ptr_width + 1;

  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            afull_q, afull_d;
  logic            aempty_q, aempty_d;
  logic            wr_acc, rd_acc;

  // Qualified strobes; reset gating keeps the datapath quiet while rst is low.
  always_comb begin
    wr_acc = rst & write & ~full_q;
    rd_acc = rst & read & ~empty_q;
  end

  assign write_to_stk = wr_acc;
  assign read_fr_stk  = rd_acc;

  // Next occupancy and flags derived from it, so flags move on the same edge as count.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CntW'(stk_height));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CntW'(af_thresh));
    aempty_d = (count_d <= CntW'(ae_thresh));
  end

  // Occupancy and status flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  fifo_ptr_wrap #(
    .stk_height    (stk_height),
    .stk_ptr_width (stk_ptr_width)
  ) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (wr_acc),
    .ptr_o  (write_ptr)
  );

  fifo_ptr_wrap #(
    .stk_height    (stk_height),
    .stk_ptr_width (stk_ptr_width)
  ) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rd_acc),
    .ptr_o  (read_ptr)
  );

  assign count        = count_q;
  assign stk_full     = full_q;
  assign stk_empty    = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags; a new event wins over a clear in the same cycle.
  always_comb begin
    ovf_d = (write & full_q) | (ovf_q & ~err_clr);
    udf_d = (read & empty_q) | (udf_q & ~err_clr);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: a height-8 and a height-6 instance share stimulus.
module tb_fifo_sync_ctrl;

  localparam int HT  [2] = '{8, 6};
  localparam int AFT [2] = '{6, 4};
  localparam int AET [2] = '{2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, write, read, err_clr;
  logic       w_stb [2];
  logic       r_stb [2];
  logic [2:0] wp    [2];
  logic [2:0] rp    [2];
  logic [3:0] cnt   [2];
  logic       full  [2];
  logic       empty [2];
  logic       af    [2];
  logic       ae    [2];
  logic       ovf   [2];
  logic       udf   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_sync_ctrl #(
      .stk_height    (HT[g]),
      .stk_ptr_width (3),
      .af_thresh     (AFT[g]),
      .ae_thresh     (AET[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .write        (write),
      .read         (read),
`ifdef FIFO_CTRL_ERR_EN
      .err_clr      (err_clr),
      .overflow     (ovf[g]),
      .underflow    (udf[g]),
`endif
      .write_to_stk (w_stb[g]),
      .read_fr_stk  (r_stb[g]),
      .write_ptr    (wp[g]),
      .read_ptr     (rp[g]),
      .stk_full     (full[g]),
      .stk_empty    (empty[g]),
      .almost_full  (af[g]),
      .almost_empty (ae[g]),
      .count        (cnt[g])
    );
`ifndef FIFO_CTRL_ERR_EN
    assign ovf[g] = 1'b0;
    assign udf[g] = 1'b0;
`endif
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy and modular pointers per instance.
  int m_cnt [2];
  int m_wp  [2];
  int m_rp  [2];
  bit m_ovf [2];
  bit m_udf [2];

  logic [3:0]  strb_q  [$];
  logic [31:0] state_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_pack(input int g, input int c, input int w, input int r,
                                           input bit o, input bit u);
    return {4'(c), 3'(w), 3'(r), c == HT[g], c == 0, c >= AFT[g], c <= AET[g], o, u};
  endfunction

  function automatic logic [15:0] obs_pack(input int g);
    return {cnt[g], wp[g], rp[g], full[g], empty[g], af[g], ae[g], ovf[g], udf[g]};
  endfunction

  function automatic logic [3:0] obs_strb();
    return {w_stb[0], r_stb[0], w_stb[1], r_stb[1]};
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_cnt[g] = 0;
      m_wp[g]  = 0;
      m_rp[g]  = 0;
      m_ovf[g] = 1'b0;
      m_udf[g] = 1'b0;
    end
  endtask

  // One clock of stimulus; expected strobes and post-edge state go to the scoreboard.
  task automatic cycle(input bit w, input bit r, input bit clr);
    logic [3:0]  es;
    logic [31:0] est;
    @(negedge clk);
    write   = w;
    read    = r;
    err_clr = clr;
    for (int g = 0; g < 2; g++) begin
      bit wa, ra;
      wa = w && (m_cnt[g] < HT[g]);
      ra = r && (m_cnt[g] > 0);
      es[3-2*g] = wa;
      es[2-2*g] = ra;
`ifdef FIFO_CTRL_ERR_EN
      m_ovf[g] = (w && m_cnt[g] == HT[g]) || (m_ovf[g] && !clr);
      m_udf[g] = (r && m_cnt[g] == 0) || (m_udf[g] && !clr);
`endif
      if (wa) m_wp[g] = (m_wp[g] + 1) % HT[g];
      if (ra) m_rp[g] = (m_rp[g] + 1) % HT[g];
      m_cnt[g] = m_cnt[g] + int'(wa) - int'(ra);
      est[16*g +: 16] = exp_pack(g, m_cnt[g], m_wp[g], m_rp[g], m_ovf[g], m_udf[g]);
    end
    strb_q.push_back(es);
    state_q.push_back(est);
  endtask

  // Strobe monitor: combinational outputs sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (strb_q.size() > 0) begin
      logic [3:0] e;
      e = strb_q.pop_front();
      chk("strobes", 32'(obs_strb()), 32'(e));
    end
  end

  // State monitor: registered outputs sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (state_q.size() > 0) begin
      logic [31:0] e;
      e = state_q.pop_front();
      chk("state_h8", 32'(obs_pack(0)), 32'(e[15:0]));
      chk("state_h6", 32'(obs_pack(1)), 32'(e[31:16]));
    end
  end

  // Reset asserted with requests pending: state and strobes must clear before any edge.
  task automatic reset_check(input string name);
    write = 1'b1;
    read  = 1'b1;
    rst   = 1'b0;
    #1;
    model_reset();
    chk({name, "_h8"}, 32'(obs_pack(0)), 32'(exp_pack(0, 0, 0, 0, 1'b0, 1'b0)));
    chk({name, "_h6"}, 32'(obs_pack(1)), 32'(exp_pack(1, 0, 0, 0, 1'b0, 1'b0)));
    chk({name, "_strb"}, 32'(obs_strb()), 32'(0));
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; err_clr = 1'b0;
    #2;
    reset_check("reset");
    @(negedge clk);
    rst = 1'b1; write = 1'b0; read = 1'b0;

    repeat (8) cycle(1, 0, 0);   // fill; h6 drops the last two
    repeat (2) cycle(1, 0, 0);   // overflow attempts
    cycle(0, 0, 1);              // clear sticky errors
    cycle(1, 1, 0);              // full with write+read: read only
    repeat (10) cycle(0, 1, 0);  // drain past empty
    cycle(1, 1, 0);              // empty with write+read: write only
    repeat (2) cycle(1, 0, 0);   // count 3
    repeat (20) cycle(1, 1, 0);  // steady streaming, pointers wrap
    repeat (2) cycle(1, 0, 0);   // count 5

    @(negedge clk);
    reset_check("midreset");
    @(negedge clk);
    rst = 1'b1; write = 1'b0; read = 1'b0;

    for (int i = 0; i < 400; i++) begin
      int wpct;
      wpct = (i < 200) ? 70 : 35;
      cycle($urandom_range(0, 99) < wpct, $urandom_range(0, 99) < 50,
            $urandom_range(0, 9) == 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(strb_q.size() + state_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
